// File: rtl/vram_wr_ctrl.sv
// vram_wr_ctrl: buffered CPU-to-VRAM port-A write controller with pixel FIFO, fill engine and status register
// Ports: clk, rst (async, active-high); mem_w/addr_bus/data_in CPU store side; rd_data/rd_hit status read;
// busy; vram_we/vram_addr/vram_din registered port-A write. Macro VRAM_WR_RECT_EN enables rectangular fills.
module vram_wr_ctrl #(
  parameter int PIX_W = 12,
  parameter int ADDR_W = 19,
  parameter int FIFO_DEPTH = 8,
  parameter logic [3:0] BASE_NIB = 4'hD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_w,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       data_in,
  output logic [31:0]       rd_data,
  output logic              rd_hit,
  output logic              busy,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [PIX_W-1:0]  vram_din
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + PIX_W;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [EW-1:0] fifo [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, pre_cnt;
  logic [ADDR_W-1:0] fill_addr, fill_len, pend_addr, pend_len, cur, rem;
  logic [PIX_W-1:0] pend_col;
  logic sel, pix_wr, ctl_wr, go_wr, st_wr, go_ok, pop, push, ovf, ovf_set, ovf_clr;
  logic pend, fill_active, last, unused;
`ifdef VRAM_WR_RECT_EN
  logic [15:0] rect_w, stride, pend_w, pend_stride, col_cnt;
  logic [ADDR_W-1:0] row_base;
`endif
  assign sel = addr_bus[31:28] == BASE_NIB;
  assign pix_wr = mem_w & sel & ~addr_bus[27];
  assign ctl_wr = mem_w & sel & addr_bus[27];
  assign go_wr = ctl_wr & (addr_bus[3:2] == 2'd2);
  assign st_wr = ctl_wr & (addr_bus[3:2] == 2'd3);
  assign rd_hit = sel & addr_bus[27] & (addr_bus[3:2] == 2'd3);
  assign fill_active = pend | (state == FILL);
  assign busy = (count != '0) | fill_active;
  assign rd_data = {16'd0, 8'(count), 5'd0, ovf, fill_active, busy};
  // pre_cnt counts entries queued ahead of a pending fill; once it reaches zero, later stores wait for the fill
  assign pop = (state == IDLE) & ((count != '0) | pix_wr) & ~(pend & (pre_cnt == '0));
  assign push = pix_wr & ((count != CW'(FIFO_DEPTH)) | pop);
  // an empty FIFO forwards the incoming store straight to the output register
  assign head = (count == '0) ? {addr_bus[ADDR_W-1:0], data_in[PIX_W-1:0]} : fifo[rd_ptr];
  assign ovf_set = (pix_wr & ~push) | (go_wr & fill_active);
  assign unused = ^{addr_bus[26:ADDR_W], data_in[31:ADDR_W]};
`ifdef VRAM_WR_RECT_EN
  assign go_ok = go_wr & ~fill_active & (fill_len != '0) & (rect_w != '0);
  assign ovf_clr = go_wr & (fill_len == '0) & data_in[2];
  assign last = (rem == ADDR_W'(1)) & (col_cnt == 16'd1);
`else
  assign go_ok = go_wr & ~fill_active & (fill_len != '0);
  assign ovf_clr = st_wr;
  assign last = rem == ADDR_W'(1);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == IDLE) ? ((pend && pre_cnt == '0) ? FILL : IDLE) : (last ? IDLE : FILL);
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= {addr_bus[ADDR_W-1:0], data_in[PIX_W-1:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {wr_ptr, rd_ptr, count, pre_cnt} <= '0;
      {fill_addr, fill_len, pend_addr, pend_len, cur, rem, pend_col} <= '0;
      {pend, ovf, vram_we, vram_addr, vram_din} <= '0;
`ifdef VRAM_WR_RECT_EN
      {rect_w, stride, pend_w, pend_stride, col_cnt, row_base} <= '0;
`endif
    end else begin
      if (ctl_wr && addr_bus[3:2] == 2'd0) fill_addr <= data_in[ADDR_W-1:0];
      if (ctl_wr && addr_bus[3:2] == 2'd1) fill_len <= data_in[ADDR_W-1:0];
`ifdef VRAM_WR_RECT_EN
      if (st_wr) {stride, rect_w} <= data_in;
`endif
      ovf <= ~ovf_clr & (ovf | ovf_set);
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
      if (go_ok) begin
        pend <= 1'b1;
        pend_addr <= fill_addr;
        pend_len <= fill_len;
        pend_col <= data_in[PIX_W-1:0];
        pre_cnt <= count - CW'(pop);
`ifdef VRAM_WR_RECT_EN
        pend_w <= rect_w;
        pend_stride <= stride;
`endif
      end else if (state == IDLE && pend) begin
        if (pre_cnt == '0) begin
          pend <= 1'b0;
          cur <= pend_addr;
          rem <= pend_len;
`ifdef VRAM_WR_RECT_EN
          row_base <= pend_addr;
          col_cnt <= pend_w;
`endif
        end else if (pop) pre_cnt <= pre_cnt - CW'(1);
      end else if (state == FILL) begin
`ifdef VRAM_WR_RECT_EN
        if (col_cnt == 16'd1) begin
          col_cnt <= pend_w;
          row_base <= row_base + ADDR_W'(pend_stride);
          cur <= row_base + ADDR_W'(pend_stride);
          rem <= rem - ADDR_W'(1);
        end else begin
          col_cnt <= col_cnt - 16'd1;
          cur <= cur + ADDR_W'(1);
        end
`else
        cur <= cur + ADDR_W'(1);
        rem <= rem - ADDR_W'(1);
`endif
      end
      vram_we <= pop | (state == FILL);
      if (state == FILL) {vram_addr, vram_din} <= {cur, pend_col};
      else if (pop) {vram_addr, vram_din} <= head;
    end
endmodule

// File: tb/tb_vram_wr_ctrl.sv
// tb_vram_wr_ctrl: directed scoreboard bench for vram_wr_ctrl
module tb_vram_wr_ctrl;
  localparam logic [31:0] PIX = 32'hD000_0000;
  localparam logic [31:0] CTL = 32'hD800_0000;
  logic clk = 1'b0;
  logic rst, mem_w, rd_hit, busy, vram_we;
  logic [31:0] addr_bus, data_in, rd_data, st;
  logic [18:0] vram_addr;
  logic [11:0] vram_din;
  logic mon_en;
  logic [30:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  vram_wr_ctrl dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .addr_bus(addr_bus), .data_in(data_in),
    .rd_data(rd_data), .rd_hit(rd_hit), .busy(busy), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_din(vram_din)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && mon_en && vram_we) begin
      logic [30:0] e;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write got addr=%h din=%h", vram_addr, vram_din);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({vram_addr, vram_din} === e) else begin
          errors++;
          $error("FAIL write_order got addr=%h din=%h exp addr=%h din=%h", vram_addr, vram_din, e[30:12], e[11:0]);
        end
      end
    end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_w = 1'b1;
    addr_bus = a;
    data_in = d;
    cyc();
    mem_w = 1'b0;
    addr_bus = '0;
    data_in = '0;
  endtask
  task automatic pix(input logic [18:0] a, input logic [11:0] d);
    exp_q.push_back({a, d});
    wr(PIX | 32'(a), 32'(d));
  endtask
  task automatic fill(input logic [18:0] a, input logic [18:0] len, input logic [11:0] c);
    wr(CTL, 32'(a));
    wr(CTL | 32'h4, 32'(len));
    for (int i = 0; i < int'(len); i++) begin
      logic [18:0] x;
      x = a + 19'(i);
      exp_q.push_back({x, c});
    end
    wr(CTL | 32'h8, 32'(c));
  endtask
  task automatic rd_status(output logic [31:0] v);
    addr_bus = CTL | 32'hC;
    #1;
    v = rd_data;
    chk("rd_hit", 32'(rd_hit), 32'd1);
    addr_bus = '0;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
    cyc();
  endtask
  initial begin
    rst = 1'b1;
    mem_w = 1'b0;
    addr_bus = '0;
    data_in = '0;
    mon_en = 1'b1;
    cyc();
    cyc();
    chk("reset_we", 32'(vram_we), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_addr", 32'(vram_addr), 32'd0);
    chk("reset_din", 32'(vram_din), 32'd0);
    rd_status(st);
    chk("reset_status", st, 32'd0);
    rst = 1'b0;
    cyc();
`ifdef VRAM_WR_RECT_EN
    wr(CTL | 32'hC, {16'd1, 16'd1});
`endif
    pix(19'h10, 12'hABC);
    chk("latency_we", 32'(vram_we), 32'd1);
    chk("latency_addr", 32'(vram_addr), 32'h10);
    chk("latency_din", 32'(vram_din), 32'hABC);
    cyc();
    chk("after_we", 32'(vram_we), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    fill(19'h100, 19'd100, 12'h123);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) pix(19'h200 + 19'(i), 12'(i + 1));
      else wr(PIX | 32'h208, 32'h9);
    end
    rd_status(st);
    chk("status_full_ovf", st, 32'h0000_0807);
`ifdef VRAM_WR_RECT_EN
    wr(CTL | 32'h4, 32'd0);
    wr(CTL | 32'h8, 32'd4);
`else
    wr(CTL | 32'hC, 32'd0);
`endif
    rd_status(st);
    chk("status_ovf_clr", st, 32'h0000_0803);
    drain(400);
    rd_status(st);
    chk("status_idle", st, 32'd0);
    fill(19'h7FFFE, 19'd4, 12'hF00);
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("fill_consecutive_we", 32'(vram_we), 32'd1);
      cyc();
    end
    chk("fill_end_we", 32'(vram_we), 32'd0);
    drain(50);
    pix(19'h300, 12'h111);
    fill(19'h400, 19'd3, 12'h222);
    pix(19'h500, 12'h333);
    drain(50);
    wr(CTL | 32'h4, 32'd0);
    wr(CTL | 32'h8, 32'h555);
    for (int i = 0; i < 5; i++) begin
      chk("len0_busy", 32'(busy), 32'd0);
      cyc();
    end
`ifdef VRAM_WR_RECT_EN
    wr(CTL | 32'hC, {16'd640, 16'd2});
    wr(CTL, 32'd0);
    wr(CTL | 32'h4, 32'd2);
    exp_q.push_back({19'd0, 12'h0F0});
    exp_q.push_back({19'd1, 12'h0F0});
    exp_q.push_back({19'd640, 12'h0F0});
    exp_q.push_back({19'd641, 12'h0F0});
    wr(CTL | 32'h8, 32'h0F0);
    drain(50);
`endif
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    wr(CTL, 32'h1000);
    wr(CTL | 32'h4, 32'd50);
    wr(CTL | 32'h8, 32'h777);
    for (int i = 0; i < 5; i++) cyc();
    chk("midfill_we", 32'(vram_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_we", 32'(vram_we), 32'd0);
    rd_status(st);
    chk("async_reset_status", st, 32'd0);
    cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_we", 32'(vram_we), 32'd0);
      chk("post_reset_busy", 32'(busy), 32'd0);
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
